// File: rtl/torque_display_pkg.sv
// Shared types for the torque bar display: latched direction and display state.
package torque_display_pkg;

   typedef enum logic [1:0] {
      DIR_FWD   = 2'b00,
      DIR_LEFT  = 2'b01,
      DIR_RIGHT = 2'b10,
      DIR_BRAKE = 2'b11
   } dir_t;

   typedef enum logic [1:0] {
      ST_OFF   = 2'b00,
      ST_TRACK = 2'b01,
      ST_DRAIN = 2'b10
   } state_t;

endpackage

// File: rtl/torque_bar_animator_tick_divider.sv
// Display tick generator: one-cycle pulse every DIV clocks, held at phase 0 while clear.
module tick_divider #(
   parameter int DIV = 2_500_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = !clear && (cnt_q == CW'(DIV - 1));

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear || tick) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/torque_bar_animator.sv
// Animated centre-out torque/direction LED bars with drain-on-direction-change and brake blink.
module torque_bar_animator
   import torque_display_pkg::*;
#(
   parameter int TORQUE_W      = 3,
   parameter int LEDS_PER_SIDE = 9,
   parameter int TICK_DIV      = 2_500_000,
   parameter int BLINK_TICKS   = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [1:0]               instruction,
   input  logic [TORQUE_W-1:0]      torque,
   output logic [LEDS_PER_SIDE-1:0] left_LED,
   output logic [LEDS_PER_SIDE-1:0] right_LED,
   output logic                     settled
);

   localparam int LVL_W  = $clog2(LEDS_PER_SIDE + 1);
   localparam int PROD_W = TORQUE_W + LVL_W;
   localparam int TMAX   = (1 << TORQUE_W) - 1;
   localparam int BW     = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [LVL_W-1:0] FULL = LVL_W'(LEDS_PER_SIDE);

   state_t            state_q, state_d;
   dir_t              dir_q, dir_d;
   logic [LVL_W-1:0]  left_q, left_d, right_q, right_d;
   logic [BW-1:0]     bcnt_q, bcnt_d;
   logic              blink_q, blink_d;
   logic              tick, blink_eff;
   logic [PROD_W-1:0] prod, level_full;
   logic [LVL_W-1:0]  level, tgt_l, tgt_r;

   function automatic logic [LVL_W-1:0] step_to(input logic [LVL_W-1:0] cur,
                                                 input logic [LVL_W-1:0] tgt);
      if (cur < tgt) return cur + 1'b1;
      if (cur > tgt) return cur - 1'b1;
      return cur;
   endfunction

   tick_divider #(.DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .clear ((state_q == ST_OFF) || !enable),
      .tick  (tick)
   );

   // Max torque maps exactly to a full bar.
   assign prod       = PROD_W'(torque) * PROD_W'(LEDS_PER_SIDE);
   assign level_full = prod / PROD_W'(TMAX);
   assign level      = level_full[LVL_W-1:0];

   always_comb begin
      tgt_l = '0;
      tgt_r = '0;
      unique case (dir_q)
         DIR_FWD:   begin tgt_l = level; tgt_r = level; end
         DIR_LEFT:  tgt_l = level;
         DIR_RIGHT: tgt_r = level;
         DIR_BRAKE: begin tgt_l = FULL;  tgt_r = FULL;  end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_OFF;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_OFF:   state_d = ST_TRACK;
         ST_TRACK: if (instruction != dir_q) state_d = ST_DRAIN;
         ST_DRAIN: if (left_q == '0 && right_q == '0) state_d = ST_TRACK;
         default:  state_d = ST_OFF;
      endcase
      if (!enable) state_d = ST_OFF;
   end

   always_comb begin
      dir_d   = dir_q;
      left_d  = left_q;
      right_d = right_q;
      bcnt_d  = bcnt_q;
      blink_d = blink_q;
      unique case (state_q)
         ST_OFF: dir_d = dir_t'(instruction);
         ST_TRACK: if (tick) begin
            left_d  = step_to(left_q, tgt_l);
            right_d = step_to(right_q, tgt_r);
         end
         ST_DRAIN: begin
            if (tick) begin
               left_d  = (left_q  == '0) ? '0 : left_q  - 1'b1;
               right_d = (right_q == '0) ? '0 : right_q - 1'b1;
            end
            if (left_q == '0 && right_q == '0) dir_d = dir_t'(instruction);
         end
         default: ;
      endcase
      if (state_q != ST_OFF) begin
         if (dir_q != DIR_BRAKE) begin
            blink_d = 1'b1;
            bcnt_d  = '0;
         end else if (tick) begin
            if (bcnt_q == BW'(BLINK_TICKS - 1)) begin
               bcnt_d  = '0;
               blink_d = !blink_q;
            end else begin
               bcnt_d = bcnt_q + 1'b1;
            end
         end
      end
      // Every entry to TRACK restarts the brake blink in its lit phase.
      if (state_d == ST_TRACK && state_q != ST_TRACK) begin
         blink_d = 1'b1;
         bcnt_d  = '0;
      end
      if (!enable) begin
         left_d  = '0;
         right_d = '0;
         bcnt_d  = '0;
         blink_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dir_q   <= DIR_FWD;
         left_q  <= '0;
         right_q <= '0;
         bcnt_q  <= '0;
         blink_q <= 1'b0;
      end else begin
         dir_q   <= dir_d;
         left_q  <= left_d;
         right_q <= right_d;
         bcnt_q  <= bcnt_d;
         blink_q <= blink_d;
      end
   end

   assign blink_eff = (dir_q != DIR_BRAKE) || blink_q;

   always_comb begin
      left_LED  = '0;
      right_LED = '0;
      for (int i = 0; i < LEDS_PER_SIDE; i++) begin
         left_LED[i]                   = (LVL_W'(i) < left_q)  && blink_eff;
         right_LED[LEDS_PER_SIDE-1-i]  = (LVL_W'(i) < right_q) && blink_eff;
      end
      settled = (state_q == ST_TRACK) && (left_q == tgt_l) && (right_q == tgt_r);
   end

endmodule

// File: tb/tb_torque_bar_animator.sv
// Bench for torque_bar_animator: directed scenarios, a scaling table and random traffic vs a reference model.
module tb_torque_bar_animator;

   localparam int TW = 3;
   localparam int N  = 9;
   localparam int TD = 4;
   localparam int BT = 2;

   logic         clk = 1'b0;
   logic         reset, enable;
   logic [1:0]   instruction;
   logic [TW-1:0] torque;
   logic [N-1:0] left_LED, right_LED;
   logic         settled;

   int checks = 0;
   int errors = 0;

   // Reference model state: 0 off, 1 track, 2 drain
   int m_st, m_l, m_r, m_dir, m_cnt, m_bcnt;
   bit m_blink;

   typedef struct {
      logic [TW-1:0] t;
      logic [N-1:0]  l;
      logic [N-1:0]  r;
   } vec_t;
   vec_t vecs[8];

   torque_bar_animator #(
      .TORQUE_W(TW), .LEDS_PER_SIDE(N), .TICK_DIV(TD), .BLINK_TICKS(BT)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .instruction(instruction),
      .torque(torque), .left_LED(left_LED), .right_LED(right_LED), .settled(settled)
   );

   always #5 clk = ~clk;

   function automatic int lvl(int t);
      return (t * N) / ((1 << TW) - 1);
   endfunction

   function automatic int tgt(bit left_side, int dir, int t);
      if (dir == 3) return N;
      if (dir == 0) return lvl(t);
      if (left_side) return (dir == 1) ? lvl(t) : 0;
      return (dir == 2) ? lvl(t) : 0;
   endfunction

   function automatic logic [N-1:0] bar_l(int l);
      return N'((1 << l) - 1);
   endfunction

   function automatic logic [N-1:0] bar_r(int l);
      return N'(((1 << l) - 1) << (N - l));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit tk, zero;
      if (reset) begin
         m_st = 0; m_l = 0; m_r = 0; m_dir = 0; m_cnt = 0; m_bcnt = 0; m_blink = 0;
      end else if (!enable) begin
         m_st = 0; m_l = 0; m_r = 0; m_cnt = 0; m_bcnt = 0; m_blink = 0;
      end else if (m_st == 0) begin
         m_dir = int'(instruction); m_st = 1; m_blink = 1; m_bcnt = 0;
      end else begin
         tk = (m_cnt == TD - 1);
         m_cnt = tk ? 0 : m_cnt + 1;
         zero = (m_l == 0 && m_r == 0);
         if (m_dir == 3) begin
            if (tk) begin
               m_bcnt++;
               if (m_bcnt == BT) begin m_bcnt = 0; m_blink = !m_blink; end
            end
         end else begin
            m_blink = 1; m_bcnt = 0;
         end
         if (m_st == 1) begin
            if (tk) begin
               m_l += (m_l < tgt(1, m_dir, torque)) ? 1 : (m_l > tgt(1, m_dir, torque)) ? -1 : 0;
               m_r += (m_r < tgt(0, m_dir, torque)) ? 1 : (m_r > tgt(0, m_dir, torque)) ? -1 : 0;
            end
            if (int'(instruction) != m_dir) m_st = 2;
         end else begin
            if (tk) begin
               if (m_l > 0) m_l--;
               if (m_r > 0) m_r--;
            end
            if (zero) begin
               m_dir = int'(instruction); m_st = 1; m_blink = 1; m_bcnt = 0;
            end
         end
      end
   endtask

   // One clock: model and DUT advance on the rising edge; compare on the falling edge.
   task automatic cyc();
      logic [N-1:0] el, er;
      logic es;
      @(posedge clk);
      model_step();
      @(negedge clk);
      el = bar_l(m_l);
      er = bar_r(m_r);
      if (m_dir == 3 && !m_blink) begin el = '0; er = '0; end
      es = (m_st == 1) && (m_l == tgt(1, m_dir, torque)) && (m_r == tgt(0, m_dir, torque));
      chk("model", {13'd0, left_LED, right_LED, settled}, {13'd0, el, er, es});
   endtask

   task automatic wait_settled(input string name);
      int n = 0;
      while (!settled && n < 80) begin cyc(); n++; end
      if (!settled) chk({name, "_timeout"}, 32'(settled), 32'd1);
   endtask

   initial begin
      int n;
      int lit, dark, other;
      vecs[0] = '{3'd1, 9'h001, 9'h100};
      vecs[1] = '{3'd3, 9'h007, 9'h1C0};
      vecs[2] = '{3'd4, 9'h01F, 9'h1F0};
      vecs[3] = '{3'd7, 9'h1FF, 9'h1FF};
      vecs[4] = '{3'd2, 9'h003, 9'h180};
      vecs[5] = '{3'd5, 9'h03F, 9'h1F8};
      vecs[6] = '{3'd6, 9'h07F, 9'h1FC};
      vecs[7] = '{3'd0, 9'h000, 9'h000};

      reset = 1; enable = 0; instruction = 0; torque = 0;
      cyc(); cyc();
      chk("reset_left", 32'(left_LED), 0);
      chk("reset_right", 32'(right_LED), 0);
      chk("reset_settled", 32'(settled), 0);

      // Ramp up at full torque
      reset = 0; enable = 1; torque = 7;
      cyc();
      repeat (3) cyc();
      chk("ramp_pre_tick", 32'(left_LED), 0);
      cyc();
      chk("ramp_first_l", 32'(left_LED), 32'h001);
      chk("ramp_first_r", 32'(right_LED), 32'h100);
      repeat (31) cyc();
      chk("ramp_not_yet", 32'(settled), 0);
      cyc();
      chk("ramp_full_l", 32'(left_LED), 32'h1FF);
      chk("ramp_full_r", 32'(right_LED), 32'h1FF);
      chk("ramp_settled", 32'(settled), 1);

      // Scaling table
      for (int i = 0; i < 8; i++) begin
         torque = vecs[i].t;
         cyc();
         wait_settled("scale");
         chk("scale_l", 32'(left_LED), 32'(vecs[i].l));
         chk("scale_r", 32'(right_LED), 32'(vecs[i].r));
      end

      // Direction change FWD -> LEFT at full torque
      torque = 7;
      wait_settled("dir_pre");
      instruction = 2'b01;
      cyc();
      chk("dir_unsettled", 32'(settled), 0);
      n = 0;
      while ((left_LED != 0 || right_LED != 0) && n < 60) begin cyc(); n++; end
      chk("dir_drain_bound", 32'(n <= 37), 1);
      wait_settled("dir_ramp");
      chk("dir_left_l", 32'(left_LED), 32'h1FF);
      chk("dir_left_r", 32'(right_LED), 0);

      // Brake from zero
      instruction = 2'b00; torque = 0;
      cyc();
      wait_settled("brake_pre");
      instruction = 2'b11; torque = 3'($urandom_range(0, 7));
      repeat (60) cyc();
      lit = 0; dark = 0; other = 0;
      for (int i = 0; i < 16; i++) begin
         cyc();
         if (left_LED == 9'h1FF && right_LED == 9'h1FF) lit++;
         else if (left_LED == 0 && right_LED == 0) dark++;
         else other++;
      end
      chk("brake_lit", 32'(lit), 8);
      chk("brake_dark", 32'(dark), 8);
      chk("brake_other", 32'(other), 0);

      // Enable drop mid-ramp at level 4
      instruction = 2'b00; torque = 0;
      cyc();
      wait_settled("drop_pre");
      torque = 7;
      n = 0;
      while (left_LED != 9'h00F && n < 60) begin cyc(); n++; end
      chk("drop_reach4", 32'(left_LED), 32'h00F);
      enable = 0;
      cyc();
      chk("drop_left", 32'(left_LED), 0);
      chk("drop_right", 32'(right_LED), 0);
      chk("drop_settled", 32'(settled), 0);
      enable = 1;
      cyc();
      repeat (3) cyc();
      chk("reen_pre_tick", 32'(left_LED), 0);
      cyc();
      chk("reen_first", 32'(left_LED), 32'h001);

      // Reset coinciding with a tick and a direction change
      n = 0;
      while (m_cnt != TD - 1 && n < 8) begin cyc(); n++; end
      reset = 1; instruction = 2'b10;
      cyc();
      chk("rst_tick_l", 32'(left_LED), 0);
      chk("rst_tick_r", 32'(right_LED), 0);
      chk("rst_tick_s", 32'(settled), 0);
      reset = 0; instruction = 2'b00;
      cyc();

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 39) == 0) instruction = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0)  torque = 3'($urandom_range(0, 7));
         enable = ($urandom_range(0, 59) != 0);
         reset  = ($urandom_range(0, 249) == 0);
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/torque_bar_animator.md
# torque_bar_animator

Parametrised, animated torque/direction bar display for the board LED bank: two LEDR bars, left LEDR[17:9] and right LEDR[8:0] in the default configuration. Each bar grows from the centre outward and ramps one LED per display tick toward a target set by torque and direction. A change of direction drains both bars to zero before the new direction is shown. Brake flashes both bars full. It sits between the motor-control core (enable, instruction, torque) and the LEDR pins.

## Interface
Parameters:
- TORQUE_W, 3: torque input width.
- LEDS_PER_SIDE, 9: LEDs per bar.
- TICK_DIV, 2_500_000: clk cycles per display tick (20 Hz at 50 MHz).
- BLINK_TICKS, 4: ticks per brake blink half-period.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  display enable.
- instruction  in  2  direction: 00 FWD, 01 LEFT, 10 RIGHT, 11 BRAKE.
- torque  in  TORQUE_W  torque magnitude.
- left_LED  out  LEDS_PER_SIDE  left bar; bit 0 is nearest the centre.
- right_LED  out  LEDS_PER_SIDE  right bar; bit LEDS_PER_SIDE-1 is nearest the centre.
- settled  out  1  high when in TRACK and both bar levels equal their targets.

## Operation
- Level scaling: level = (torque * LEDS_PER_SIDE) / (2^TORQUE_W - 1), floor division.
  - Product width is TORQUE_W + LVL_W, where LVL_W = $clog2(LEDS_PER_SIDE+1).
  - Maximum torque gives a full bar; torque 0 gives 0.
- Targets by latched direction dir_q:
  - FWD: left = right = level.
  - LEFT: left = level, right = 0.
  - RIGHT: right = level, left = 0.
  - BRAKE: left = right = LEDS_PER_SIDE, regardless of torque.
- Bar decode:
  - left_LED[i] = (i < left_lvl).
  - right_LED[LEDS_PER_SIDE-1-i] = (i < right_lvl).
  - In BRAKE, both outputs are ANDed with blink_on.
- States:
  - OFF: levels, tick counter, blink counter = 0; outputs 0; settled 0. On enable=1, latch dir_q = instruction and go to TRACK.
  - TRACK: on each tick, each level steps ±1 toward its target; it holds when equal. Targets follow live torque. If instruction != dir_q, go to DRAIN; the same-cycle tick still applies a TRACK step.
  - DRAIN: on each tick, both levels decrement, saturating at 0; dir_q holds. In the first cycle with both levels 0, latch dir_q = current instruction and go to TRACK. Instruction reverting to the old dir_q does not abort the drain.
- enable=0 in any state → OFF on the next edge.
- Blink: blink_on = 1 on entry to TRACK with dir_q = BRAKE. It toggles every BLINK_TICKS ticks while in BRAKE, and is forced to 1 outside BRAKE.
- Reset dominates enable, tick and direction change: all registers clear, state = OFF.

## Timing
- Reset values: left_LED = 0, right_LED = 0, settled = 0, state = OFF, dir_q = FWD.
- Outputs are combinational decodes of registered state. They change right after the clock edge that updates the registers; there is no extra output stage.
- Tick counter:
  - Counts 0..TICK_DIV-1 and is held at 0 in OFF.
  - tick = 1 when count == TICK_DIV-1; the counter then wraps.
  - The first tick occurs TICK_DIV cycles after entering TRACK.
- Latency:
  - OFF→TRACK: 1 cycle after enable rises.
  - Full ramp from 0 to N: N ticks.
  - Direction change: 1 cycle to DRAIN, then max(left_lvl, right_lvl) ticks, then 1 cycle to TRACK, then the new ramp.
- Level registers never exceed LEDS_PER_SIDE and never underflow below 0.

## Structure
- torque_display_pkg:
  - dir_t enum: DIR_FWD, DIR_LEFT, DIR_RIGHT, DIR_BRAKE.
  - state_t enum: ST_OFF, ST_TRACK, ST_DRAIN.
- Sub-module tick_divider (params DIV; ports clk, reset, clear, tick) generates the display tick.
- Level scaling, target selection, state machine and bar decode live in torque_bar_animator.

## Test plan
All scenarios use TORQUE_W=3, LEDS_PER_SIDE=9, TICK_DIV=4, BLINK_TICKS=2.
- Ramp up: reset, then enable=1, instruction=00, torque=7 → both bars gain one LED every 4 cycles. After 9 ticks, left_LED = right_LED = 9'h1FF and settled=1.
- Scaling: FWD, torque=4, settled → left_LED = 9'b000011111, right_LED = 9'b111110000. Torque 1 gives one LED; torque 3 gives three.
- Direction change: from FWD torque=7 settled, set instruction=01 → settled=0 and both bars drain to 0 over 9 ticks. Then left ramps to 9'h1FF over 9 ticks while right_LED stays 0.
- Brake: from zero, instruction=11 (any torque) → bars ramp to full, lit phase first. Once full, both outputs alternate 9'h1FF / 0 every 2 ticks.
- Enable drop mid-ramp at level 4 → outputs 0 next cycle, settled=0. Re-enable → ramp restarts from 0, first step 4 cycles later.
- Reset asserted in the same cycle as a tick and a direction change → next cycle all outputs 0, state OFF, dir_q=FWD.
